drone_esc_pwm_gen: RTL and testbench
====================================

// Module: drone_esc_pwm_gen
// PURPOSE
//  Consumes the four motor throttle words written over AXI4-Lite into the BLDC motor-ctrl register bank.
//  Generates four ESC servo-style PWM outputs: pulse = MIN_PULSE_US + throttle (us), fixed frame period.
//  New commands are double-buffered and take effect only at frame boundaries, so no pulse is ever truncated or glitched.
//  Sits directly downstream of the register bank; its outputs drive the drone's four ESC input pins.
// PARAMETERS
//  TICK_DIV      100    ACLK cycles per 1 us tick (100 MHz ACLK)
//  PERIOD_US     2500   frame period in us (400 Hz); must be > MIN_PULSE_US+THR_MAX
//  MIN_PULSE_US  1000   pulse width at throttle 0
//  THR_MAX       1000   throttle saturation value (gives 2000 us max pulse)
//  CMD_W         16     width of each throttle word
//  WDT_FRAMES    50     frames without cmd_valid before watchdog trips (ESC_WATCHDOG_EN only)
// PORTS
//  ACLK         in   1        system clock
//  ARESET       in   1        asynchronous reset, active-high
//  cmd_in       in   4*CMD_W  throttle words; motor n at [n*CMD_W +: CMD_W]
//  cmd_valid    in   1        1-cycle strobe: cmd_in is new (register-bank write)
//  arm          in   1        1 = armed; 0 = force throttle 0
//  pwm_out      out  4        ESC PWM, bit n = motor n
//  frame_start  out  1        1-cycle pulse at the start of each frame
//  wdt_expired  out  1        sticky watchdog flag
// BEHAVIOUR
//  - Reset (async, immediate): all counters, staging, active, pending cleared.
//    Outputs: pwm_out=0, frame_start=0, wdt_expired=0.
//  - Prescaler us_cnt: 0..TICK_DIV-1. tick=1 in the cycle us_cnt==TICK_DIV-1, then us_cnt wraps to 0.
//  - Frame counter p_cnt: 0..PERIOD_US-1, advances on tick. Wrap = tick && p_cnt==PERIOD_US-1.
//  - frame_start registered: high for exactly 1 cycle, the cycle after wrap.
//  - cmd_valid: staging[n] <= min(cmd_in word n, THR_MAX) (unsigned compare); pending <= 1.
//  - At wrap: if pending, active <= staging (or 0 where arm==0); pending <= 0.
//    If not pending, active is held, except arm==0 forces active to 0.
//  - cmd_valid in the same cycle as wrap: active loads the OLD staging; the new value goes to staging;
//    pending stays 1 and the new value applies at the next wrap.
//  - arm is sampled only at wrap; it never changes a pulse already in progress.
//  - pwm_out[n] registered: <= (p_cnt < MIN_PULSE_US + active[n]); 1-cycle latency from p_cnt.
//    First cycle after reset release: pwm_out=1 (p_cnt=0).
//  - Pulse width is exactly (MIN_PULSE_US+active)*TICK_DIV ACLK cycles; period is PERIOD_US*TICK_DIV.
//  - Arithmetic: p_cnt and pulse-limit width is clog2(PERIOD_US); active is clog2(THR_MAX+1) bits.
// CONFIGURATION
//  `ESC_WATCHDOG_EN defined:
//    - frame counter wd_cnt increments at each wrap and clears on cmd_valid.
//    - When wd_cnt reaches WDT_FRAMES: wdt_expired<=1 and active is forced to 0 at every wrap.
//    - The first forced frame is the one starting at the wrap that trips the watchdog.
//    - cmd_valid clears wdt_expired and wd_cnt; the new command applies at the next wrap.
//  `ESC_WATCHDOG_EN undefined: no wd_cnt logic; wdt_expired tied 0.
// TESTING
//  1 reset, arm=1, no cmd -> pwm_out=4'hF for 100000 clk of every 250000; frame_start every 250000 clk.
//  2 cmd0=500 + cmd_valid mid-frame -> current pulse stays 1000 us; next frame ch0 = 150000 clk.
//  3 cmd1=1500 -> saturated; ch1 pulse 2000 us (200000 clk).
//  4 ch2=800 active, arm->0 mid-frame -> current pulse 1800 us; next 1000 us.
//  5 cmd_valid(cmd3=300) in wrap cycle -> next frame old value; frame after that 1300 us.
//  6 ESC_WATCHDOG_EN, WDT_FRAMES=4, ch0=700, no cmd -> wdt_expired=1 after 4 wraps; pulse 1000 us.
//    Then cmd_valid clears the flag; next frame uses the new command.
//  7 ARESET mid-pulse -> pwm_out=0 same cycle; restart with 1000 us pulses.

Source files
------------

// File: rtl/drone_esc_pwm_gen.sv
// Four-channel ESC servo PWM generator with frame-boundary double buffering of throttle commands.
// Optional command-loss watchdog is compiled in when ESC_WATCHDOG_EN is defined.
module drone_esc_pwm_gen #(
    parameter int TICK_DIV     = 100,
    parameter int PERIOD_US    = 2500,
    parameter int MIN_PULSE_US = 1000,
    parameter int THR_MAX      = 1000,
    parameter int CMD_W        = 16,
    parameter int WDT_FRAMES   = 50
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [4*CMD_W-1:0] cmd_in,
    input  logic               cmd_valid,
    input  logic               arm,
    output logic [3:0]         pwm_out,
    output logic               frame_start,
    output logic               wdt_expired
);

    localparam int P_W = $clog2(PERIOD_US);
    localparam int A_W = $clog2(THR_MAX + 1);
    localparam int U_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [U_W-1:0]            r_usCnt;
    logic [P_W-1:0]            r_pCnt;
    logic                      r_frameStart;
    logic [3:0]                r_pwm;
    logic [3:0][A_W-1:0]       r_staging;
    logic [3:0][A_W-1:0]       r_active;
    logic                      r_pending;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_force;
    logic                      w_wdForce;
    logic [3:0][CMD_W-1:0]     w_word;
    logic [3:0][A_W-1:0]       w_sat;
    logic [3:0][P_W-1:0]       w_limit;

    assign w_tick = (r_usCnt == U_W'(TICK_DIV - 1));
    assign w_wrap = w_tick && (r_pCnt == P_W'(PERIOD_US - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_usCnt      <= '0;
            r_pCnt       <= '0;
            r_frameStart <= 1'b0;
        end else begin
            r_usCnt      <= w_tick ? '0 : r_usCnt + 1'b1;
            r_frameStart <= w_wrap;
            if (w_wrap)
                r_pCnt <= '0;
            else if (w_tick)
                r_pCnt <= r_pCnt + 1'b1;
        end
    end

    always_comb begin
        w_word  = '0;
        w_sat   = '0;
        w_limit = '0;
        for (int n = 0; n < 4; n++) begin
            w_word[n]  = cmd_in[n*CMD_W +: CMD_W];
            w_sat[n]   = (w_word[n] > CMD_W'(THR_MAX)) ? A_W'(THR_MAX) : w_word[n][A_W-1:0];
            w_limit[n] = P_W'(MIN_PULSE_US) + P_W'(r_active[n]);
        end
    end

`ifdef ESC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDT_FRAMES + 1);

    logic [WD_W-1:0] r_wdCnt;
    logic            r_wdExpired;

    // The wrap that brings the count to WDT_FRAMES already forces its frame to idle.
    assign w_wdForce = r_wdExpired || (!cmd_valid && (r_wdCnt >= WD_W'(WDT_FRAMES - 1)));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wdCnt     <= '0;
            r_wdExpired <= 1'b0;
        end else if (cmd_valid) begin
            r_wdCnt     <= '0;
            r_wdExpired <= 1'b0;
        end else if (w_wrap) begin
            if (r_wdCnt < WD_W'(WDT_FRAMES))
                r_wdCnt <= r_wdCnt + 1'b1;
            if (r_wdCnt >= WD_W'(WDT_FRAMES - 1))
                r_wdExpired <= 1'b1;
        end
    end

    assign wdt_expired = r_wdExpired;
`else
    assign w_wdForce   = 1'b0;
    assign wdt_expired = 1'b0;
`endif

    assign w_force = !arm || w_wdForce;

    // A cmd_valid coinciding with wrap lands in staging after the wrap has consumed the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_staging <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrap) begin
                for (int n = 0; n < 4; n++) begin
                    if (w_force)
                        r_active[n] <= '0;
                    else if (r_pending)
                        r_active[n] <= r_staging[n];
                end
                r_pending <= 1'b0;
            end
            if (cmd_valid) begin
                r_staging <= w_sat;
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_pwm <= '0;
        end else begin
            for (int n = 0; n < 4; n++)
                r_pwm[n] <= (r_pCnt < w_limit[n]);
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_drone_esc_pwm_gen.sv
// Self-checking bench for drone_esc_pwm_gen: measures per-frame pulse widths and compares them
// with a frame-level model of staging/pending/arm/watchdog behaviour; scaled-down timing parameters.
module tb_drone_esc_pwm_gen;

    localparam int TICK_DIV     = 3;
    localparam int PERIOD_US    = 40;
    localparam int MIN_PULSE_US = 10;
    localparam int THR_MAX      = 20;
    localparam int CMD_W        = 16;
    localparam int WDT_FRAMES   = 4;
    localparam int FRAME_CLK    = TICK_DIV * PERIOD_US;

    logic               ACLK = 1'b0;
    logic               ARESET = 1'b1;
    logic [4*CMD_W-1:0] cmd_in = '0;
    logic               cmd_valid = 1'b0;
    logic               arm = 1'b1;
    logic [3:0]         pwm_out;
    logic               frame_start;
    logic               wdt_expired;

    int errors = 0;
    int checks = 0;

    int mActive[4];
    int mStaging[4];
    bit mPending;
    int mWd;
    bit mExp;

    int measWidth[4];
    int measLen;
    bit armAtWrap;

    drone_esc_pwm_gen #(
        .TICK_DIV    (TICK_DIV),
        .PERIOD_US   (PERIOD_US),
        .MIN_PULSE_US(MIN_PULSE_US),
        .THR_MAX     (THR_MAX),
        .CMD_W       (CMD_W),
        .WDT_FRAMES  (WDT_FRAMES)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .cmd_in     (cmd_in),
        .cmd_valid  (cmd_valid),
        .arm        (arm),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .wdt_expired(wdt_expired)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4*CMD_W-1:0] packCmd(input int a, input int b, input int c, input int d);
        return {CMD_W'(d), CMD_W'(c), CMD_W'(b), CMD_W'(a)};
    endfunction

    function automatic int satThr(input int v);
        return (v > THR_MAX) ? THR_MAX : v;
    endfunction

    task automatic modelReset();
        for (int n = 0; n < 4; n++) begin
            mActive[n]  = 0;
            mStaging[n] = 0;
        end
        mPending = 0;
        mWd      = 0;
        mExp     = 0;
    endtask

    // Frame-level model: what the outputs must look like after the frame's closing wrap.
    task automatic modelWrap(input bit doCmd, input int cmdOff, input logic [4*CMD_W-1:0] word, input bit armWrap);
        bit force0;
        bit cmdAtWrap;
        cmdAtWrap = doCmd && (cmdOff == FRAME_CLK);
        if (doCmd && !cmdAtWrap) begin
            for (int n = 0; n < 4; n++) mStaging[n] = satThr(int'(word[n*CMD_W +: CMD_W]));
            mPending = 1;
            mWd      = 0;
            mExp     = 0;
        end
        force0 = !armWrap;
`ifdef ESC_WATCHDOG_EN
        if (cmdAtWrap) begin
            force0 = force0 || mExp;
            mWd    = 0;
            mExp   = 0;
        end else begin
            mWd++;
            if (mWd >= WDT_FRAMES) mExp = 1;
            force0 = force0 || mExp;
        end
`endif
        for (int n = 0; n < 4; n++) begin
            if (force0)
                mActive[n] = 0;
            else if (mPending)
                mActive[n] = mStaging[n];
        end
        mPending = 0;
        if (cmdAtWrap) begin
            for (int n = 0; n < 4; n++) mStaging[n] = satThr(int'(word[n*CMD_W +: CMD_W]));
            mPending = 1;
        end
    endtask

    // Drives one frame from a frame boundary (or reset release) to the next frame_start.
    task automatic applyStimulus(input bit doCmd, input int cmdOff, input logic [4*CMD_W-1:0] word,
                                 input bit armVal, input int armOff, input bit firstCheck);
        bit done;
        done    = 0;
        measLen = 0;
        for (int n = 0; n < 4; n++) measWidth[n] = 0;
        armAtWrap = arm;
        for (int i = 1; i <= 2 * FRAME_CLK && !done; i++) begin
            cmd_valid = doCmd && (i == cmdOff);
            if (cmd_valid) cmd_in = word;
            if (i >= armOff) arm = armVal;
            if (i == FRAME_CLK) armAtWrap = arm;
            @(negedge ACLK);
            measLen++;
            for (int n = 0; n < 4; n++) measWidth[n] += int'(pwm_out[n]);
            if (firstCheck && i == 1) checkOutput("first_cycle_pwm", int'(pwm_out), 15);
            if (frame_start === 1'b1) done = 1;
        end
        cmd_valid = 1'b0;
        if (!done) checkOutput("frame_start_timeout", 0, 1);
    endtask

    task automatic doFrame(input bit doCmd, input int cmdOff, input logic [4*CMD_W-1:0] word,
                           input bit armVal, input int armOff, input bit firstCheck);
        int expW[4];
        for (int n = 0; n < 4; n++) expW[n] = (MIN_PULSE_US + mActive[n]) * TICK_DIV;
        applyStimulus(doCmd, cmdOff, word, armVal, armOff, firstCheck);
        checkOutput("frame_len", measLen, FRAME_CLK);
        for (int n = 0; n < 4; n++) checkOutput($sformatf("pulse_width_ch%0d", n), measWidth[n], expW[n]);
        modelWrap(doCmd, cmdOff, word, armAtWrap);
        checkOutput("wdt_expired", int'(wdt_expired), int'(mExp));
    endtask

    initial begin
        logic [4*CMD_W-1:0] w;
        int v[4];

        $display("[TB] start, frame=%0d clk", FRAME_CLK);
        modelReset();
        repeat (3) @(negedge ACLK);
        checkOutput("reset_pwm", int'(pwm_out), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        checkOutput("reset_wdt", int'(wdt_expired), 0);

        // Reset release, armed, no command: minimum pulses every frame.
        ARESET = 1'b0;
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 1);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);

        // Mid-frame command including a saturating channel.
        w = packCmd(15, 30, 12, 5);
        doFrame(1, 50, w, 1, FRAME_CLK + 1, 0);
        checkOutput("cmd_frame_ch0_unchanged", measWidth[0], MIN_PULSE_US * TICK_DIV);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        checkOutput("next_frame_ch0", measWidth[0], (MIN_PULSE_US + 15) * TICK_DIV);
        checkOutput("sat_ch1", measWidth[1], (MIN_PULSE_US + THR_MAX) * TICK_DIV);

        // Disarm mid-frame: current pulse kept, next frame idle, stays idle after re-arm.
        doFrame(0, 0, '0, 0, 40, 0);
        checkOutput("disarm_frame_ch2", measWidth[2], (MIN_PULSE_US + 12) * TICK_DIV);
        doFrame(0, 0, '0, 0, 1, 0);
        checkOutput("disarmed_ch2", measWidth[2], MIN_PULSE_US * TICK_DIV);
        doFrame(0, 0, '0, 1, 1, 0);

        // Restore, then a command exactly in the wrap cycle.
        doFrame(1, 30, packCmd(4, 8, 16, 2), 1, FRAME_CLK + 1, 0);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        doFrame(1, FRAME_CLK, packCmd(4, 8, 16, 9), 1, FRAME_CLK + 1, 0);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        checkOutput("wrap_cmd_old_ch3", measWidth[3], (MIN_PULSE_US + 2) * TICK_DIV);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        checkOutput("wrap_cmd_new_ch3", measWidth[3], (MIN_PULSE_US + 9) * TICK_DIV);

        // Command starvation (watchdog trips when enabled), then a fresh command.
        for (int k = 0; k < WDT_FRAMES + 2; k++) doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        doFrame(1, 60, packCmd(7, 3, 11, 18), 1, FRAME_CLK + 1, 0);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);
        checkOutput("post_starve_ch0", measWidth[0], (MIN_PULSE_US + 7) * TICK_DIV);

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            for (int n = 0; n < 4; n++)
                v[n] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16'hFF00, 16'hFFFF))
                                                   : int'($urandom_range(0, 2 * THR_MAX));
            doFrame(bit'($urandom_range(0, 2) != 0), int'($urandom_range(1, FRAME_CLK)),
                    packCmd(v[0], v[1], v[2], v[3]), bit'($urandom_range(0, 5) != 0),
                    int'($urandom_range(1, FRAME_CLK + 5)), 0);
        end

        // Asynchronous reset in the middle of a pulse.
        doFrame(0, 0, '0, 1, 1, 0);
        repeat (5) @(negedge ACLK);
        checkOutput("pre_reset_pwm_high", int'(pwm_out), 15);
        ARESET = 1'b1;
        #1;
        checkOutput("async_reset_pwm", int'(pwm_out), 0);
        checkOutput("async_reset_frame_start", int'(frame_start), 0);
        checkOutput("async_reset_wdt", int'(wdt_expired), 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        modelReset();
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 1);
        doFrame(0, 0, '0, 1, FRAME_CLK + 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
